// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: mstatus/mie/mip CSRs, priority select, req/ack trap handshake.
// Optional IRQ_CTRL_EXT_SYNC_EN: ext_irq passes through a MIP_EXT_STAGES-flop synchronizer.
module irq_ctrl #(
  parameter int MIP_EXT_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        timer_irq,
  input  logic        sw_irq,
  input  logic        ext_irq,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_hit,
  output logic        irq_req,
  output logic [31:0] irq_cause,
  input  logic        irq_ack,
  input  logic        mret,
  output logic        mie_global,
  output logic        dbg_state
);

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t      r_state;
  logic        r_mie;
  logic        r_mpie;
  logic [2:0]  r_mie_en;     // {MEIE, MTIE, MSIE}
  logic        r_irq_req;
  logic [31:0] r_irq_cause;

  logic        w_ext;
  logic [2:0]  w_mip;        // {MEIP, MTIP, MSIP}
  logic [2:0]  w_pend;
  logic [3:0]  w_win_code;
  logic        w_latched_pend;
  logic        w_wr;
  logic        w_ack_take;
  logic        w_unused_wdata;

  if (MIP_EXT_STAGES < 1) begin : g_param_check
    $error("MIP_EXT_STAGES must be at least 1");
  end

`ifdef IRQ_CTRL_EXT_SYNC_EN
  logic [MIP_EXT_STAGES-1:0] r_ext_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ext_sync <= '0;
    else        r_ext_sync <= MIP_EXT_STAGES'({r_ext_sync, ext_irq});
  end

  assign w_ext = r_ext_sync[MIP_EXT_STAGES-1];
`else
  assign w_ext = ext_irq;
`endif

  assign w_mip  = {w_ext, timer_irq, sw_irq};
  assign w_pend = w_mip & r_mie_en;

  // Fixed priority MEI > MSI > MTI.
  always_comb begin
    w_win_code = 4'd7;
    if (w_pend[2])      w_win_code = 4'd11;
    else if (w_pend[0]) w_win_code = 4'd3;
  end

  always_comb begin
    case (r_irq_cause[3:0])
      4'd11:   w_latched_pend = w_pend[2];
      4'd7:    w_latched_pend = w_pend[1];
      4'd3:    w_latched_pend = w_pend[0];
      default: w_latched_pend = 1'b0;
    endcase
  end

  always_comb begin
    csr_rdata = '0;
    csr_hit   = 1'b0;
    case (csr_addr)
      12'h300: begin
        csr_hit   = 1'b1;
        csr_rdata = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
      end
      12'h304: begin
        csr_hit   = 1'b1;
        csr_rdata = {20'b0, r_mie_en[2], 3'b0, r_mie_en[1], 3'b0, r_mie_en[0], 3'b0};
      end
      12'h344: begin
        csr_hit   = 1'b1;
        csr_rdata = {20'b0, w_mip[2], 3'b0, w_mip[1], 3'b0, w_mip[0], 3'b0};
      end
      default: ;
    endcase
  end

  function automatic logic csr_bit(input logic cur, input logic [1:0] op, input logic w);
    case (op)
      2'b01:   csr_bit = w;
      2'b10:   csr_bit = cur | w;
      2'b11:   csr_bit = cur & ~w;
      default: csr_bit = cur;
    endcase
  endfunction

  assign w_wr       = (csr_op != 2'b00);
  // Handshake: irq_req is valid, irq_ack is ready; the trap is taken on any edge where both are 1,
  // and irq_cause is frozen from the rise of irq_req until that edge.
  assign w_ack_take = (r_state == ST_REQ) && irq_ack;
  assign w_unused_wdata = &{1'b0, csr_wdata[31:12], csr_wdata[10:8], csr_wdata[6:4], csr_wdata[2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mie       <= 1'b0;
      r_mpie      <= 1'b0;
      r_mie_en    <= 3'b000;
      r_irq_req   <= 1'b0;
      r_irq_cause <= '0;
    end else begin
      // Trap entry beats mret, which beats a software write of mstatus.
      if (w_ack_take) begin
        r_mpie <= r_mie;
        r_mie  <= 1'b0;
      end else if (mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end else if (w_wr && csr_addr == 12'h300) begin
        r_mie  <= csr_bit(r_mie,  csr_op, csr_wdata[3]);
        r_mpie <= csr_bit(r_mpie, csr_op, csr_wdata[7]);
      end

      if (w_wr && csr_addr == 12'h304) begin
        r_mie_en[0] <= csr_bit(r_mie_en[0], csr_op, csr_wdata[3]);
        r_mie_en[1] <= csr_bit(r_mie_en[1], csr_op, csr_wdata[7]);
        r_mie_en[2] <= csr_bit(r_mie_en[2], csr_op, csr_wdata[11]);
      end

      case (r_state)
        ST_IDLE: begin
          if (r_mie && (w_pend != 3'b000)) begin
            r_state     <= ST_REQ;
            r_irq_req   <= 1'b1;
            r_irq_cause <= {1'b1, 27'b0, w_win_code};
          end
        end
        ST_REQ: begin
          if (irq_ack || !r_mie || !w_latched_pend) begin
            r_state   <= ST_IDLE;
            r_irq_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_irq_req <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req    = r_irq_req;
  assign irq_cause  = r_irq_cause;
  assign mie_global = r_mie;
  assign dbg_state  = (r_state == ST_REQ);

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed and randomized bench for irq_ctrl against a CSR-level reference model.
module tb_irq_ctrl;

  localparam int EXT_STAGES = 2;

  logic        clk;
  logic        rst_n;
  logic        timer_irq;
  logic        sw_irq;
  logic        ext_irq;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic        irq_req;
  logic [31:0] irq_cause;
  logic        irq_ack;
  logic        mret;
  logic        mie_global;
  logic        dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  // Reference model state
  logic        m_mie, m_mpie, m_req;
  logic [31:0] m_mie_reg, m_cause;
  logic        n_mie, n_mpie, n_req;
  logic [31:0] n_mie_reg, n_cause;
`ifdef IRQ_CTRL_EXT_SYNC_EN
  logic [EXT_STAGES-1:0] m_ext_pipe;
`endif

  irq_ctrl #(.MIP_EXT_STAGES(EXT_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .timer_irq(timer_irq), .sw_irq(sw_irq), .ext_irq(ext_irq),
    .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .csr_hit(csr_hit), .irq_req(irq_req), .irq_cause(irq_cause), .irq_ack(irq_ack),
    .mret(mret), .mie_global(mie_global), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] apply_op(input logic [31:0] cur, input logic [1:0] op,
                                           input logic [31:0] wd, input logic [31:0] mask);
    case (op)
      2'b01:   return wd & mask;
      2'b10:   return cur | (wd & mask);
      2'b11:   return cur & ~(wd & mask);
      default: return cur;
    endcase
  endfunction

  function automatic logic m_ext_line();
`ifdef IRQ_CTRL_EXT_SYNC_EN
    return m_ext_pipe[EXT_STAGES-1];
`else
    return ext_irq;
`endif
  endfunction

  function automatic logic [31:0] m_mip();
    return (32'(sw_irq) << 3) | (32'(timer_irq) << 7) | (32'(m_ext_line()) << 11);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      12'h304: return m_mie_reg;
      12'h344: return m_mip();
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_hit(input logic [11:0] a);
    return (a == 12'h300) || (a == 12'h304) || (a == 12'h344);
  endfunction

  task automatic model_reset();
    m_mie = 1'b0; m_mpie = 1'b0; m_req = 1'b0; m_mie_reg = '0; m_cause = '0;
`ifdef IRQ_CTRL_EXT_SYNC_EN
    m_ext_pipe = '0;
`endif
  endtask

  // Next state from the architectural rules, using inputs held before the edge.
  task automatic model_next();
    logic [31:0] pend, ms;
    int code;
    bit trap;
    pend = m_mip() & m_mie_reg;
    trap = 1'b0; n_req = m_req; n_cause = m_cause;
    if (!m_req) begin
      if (m_mie && pend != 0) begin
        if (pend[11])     code = 11;
        else if (pend[3]) code = 3;
        else              code = 7;
        n_req = 1'b1;
        n_cause = 32'h8000_0000 + 32'(code);
      end
    end else if (irq_ack) begin
      n_req = 1'b0; trap = 1'b1;
    end else if (!m_mie || pend[m_cause[3:0]] == 1'b0) begin
      n_req = 1'b0;
    end
    ms = (32'(m_mie) << 3) | (32'(m_mpie) << 7);
    if (trap) begin
      n_mpie = m_mie; n_mie = 1'b0;
    end else if (mret) begin
      n_mie = m_mpie; n_mpie = 1'b1;
    end else begin
      if (csr_addr == 12'h300) ms = apply_op(ms, csr_op, csr_wdata, 32'h88);
      n_mie = ms[3]; n_mpie = ms[7];
    end
    n_mie_reg = (csr_addr == 12'h304) ? apply_op(m_mie_reg, csr_op, csr_wdata, 32'h888) : m_mie_reg;
  endtask

  // Driver: one clock with model update, trap scoreboard and post-edge checks.
  task automatic tick();
    model_next();
    if (m_req && irq_ack) begin
      exp_q.push_back(m_cause);
      check("trap_cause", irq_cause, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
`ifdef IRQ_CTRL_EXT_SYNC_EN
    m_ext_pipe = EXT_STAGES'({m_ext_pipe, ext_irq});
`endif
    m_mie = n_mie; m_mpie = n_mpie; m_req = n_req; m_mie_reg = n_mie_reg; m_cause = n_cause;
    check("irq_req", 32'(irq_req), 32'(m_req));
    check("dbg_state", 32'(dbg_state), 32'(m_req));
    check("mie_global", 32'(mie_global), 32'(m_mie));
    if (m_req) check("irq_cause", irq_cause, m_cause);
  endtask

  task automatic csr_do(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
    csr_addr = a; csr_op = op; csr_wdata = wd;
    tick();
    csr_op = 2'b00; csr_wdata = '0;
  endtask

  task automatic rd_expect(input string tag, input logic [11:0] a, input logic [31:0] want);
    csr_addr = a; csr_op = 2'b00;
    #1;
    check(tag, csr_rdata, want);
    check({tag, "_model"}, csr_rdata, m_read(a));
    check({tag, "_hit"}, 32'(csr_hit), 32'(m_hit(a)));
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic pulse_mret();
    mret = 1'b1; tick(); mret = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; timer_irq = 1'b0; sw_irq = 1'b0; ext_irq = 1'b0; irq_ack = 1'b0; mret = 1'b0;
    csr_addr = '0; csr_op = 2'b00; csr_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_irq_req", 32'(irq_req), 32'h0);
    check("rst_irq_cause", irq_cause, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_expect("rst_mstatus", 12'h300, 32'h0000_1800);
    rd_expect("rst_mie", 12'h304, 32'h0);
    rd_expect("rst_mip", 12'h344, 32'h0);
    rd_expect("miss_rd", 12'h305, 32'h0);
    check("rst_mie_global", 32'(mie_global), 32'h0);

    // Timer interrupt, trap entry, mret
    csr_do(12'h304, 2'b01, 32'h80);
    csr_do(12'h300, 2'b10, 32'h8);
    timer_irq = 1'b1;
    rd_expect("mip_timer_comb", 12'h344, 32'h80);
    tick();
    check("mti_req", 32'(irq_req), 32'h1);
    check("mti_cause", irq_cause, 32'h8000_0007);
    pulse_ack();
    check("ack_req_low", 32'(irq_req), 32'h0);
    check("ack_mie_low", 32'(mie_global), 32'h0);
    rd_expect("ack_mstatus", 12'h300, 32'h1880);
    timer_irq = 1'b0;
    pulse_mret();
    rd_expect("mret_mstatus", 12'h300, 32'h1888);

    // All three sources: MEI wins and is held until ack
    csr_do(12'h304, 2'b01, 32'h888);
    csr_do(12'h300, 2'b11, 32'h8);
    timer_irq = 1'b1; sw_irq = 1'b1; ext_irq = 1'b1;
    repeat (3) tick();
    csr_do(12'h300, 2'b10, 32'h8);
    tick();
    check("mei_cause", irq_cause, 32'h8000_000B);
    repeat (4) tick();
    check("mei_hold_req", 32'(irq_req), 32'h1);
    check("mei_hold_cause", irq_cause, 32'h8000_000B);
    pulse_ack();
    timer_irq = 1'b0; sw_irq = 1'b0; ext_irq = 1'b0;
    pulse_mret();
    repeat (4) tick();

    // No re-prioritisation while requesting
    timer_irq = 1'b1;
    tick();
    check("mti_only_cause", irq_cause, 32'h8000_0007);
    ext_irq = 1'b1; sw_irq = 1'b1;
    repeat (4) tick();
    check("no_reprio_cause", irq_cause, 32'h8000_0007);
    ext_irq = 1'b0; sw_irq = 1'b0;
    repeat (3) tick();

    // Withdraw by clearing MTIE, then the same with ack in the withdraw cycle
    csr_do(12'h304, 2'b11, 32'h80);
    check("wd_req_still", 32'(irq_req), 32'h1);
    tick();
    check("wd_req_drop", 32'(irq_req), 32'h0);
    csr_do(12'h304, 2'b10, 32'h80);
    tick();
    check("rereq", 32'(irq_req), 32'h1);
    csr_do(12'h304, 2'b11, 32'h80);
    pulse_ack();
    check("wd_ack_mie", 32'(mie_global), 32'h0);
    rd_expect("wd_ack_mstatus", 12'h300, 32'h1880);

    // Ack against mstatus write, ack against mret, mret against mstatus write
    pulse_mret();
    csr_do(12'h304, 2'b10, 32'h80);
    tick();
    check("ackwr_req", 32'(irq_req), 32'h1);
    csr_addr = 12'h300; csr_op = 2'b01; csr_wdata = 32'h8; irq_ack = 1'b1;
    tick();
    csr_op = 2'b00; irq_ack = 1'b0;
    rd_expect("ack_vs_wr", 12'h300, 32'h1880);
    pulse_mret();
    tick();
    check("ackmret_req", 32'(irq_req), 32'h1);
    irq_ack = 1'b1; mret = 1'b1;
    tick();
    irq_ack = 1'b0; mret = 1'b0;
    rd_expect("ack_vs_mret", 12'h300, 32'h1880);
    timer_irq = 1'b0;
    csr_addr = 12'h300; csr_op = 2'b01; csr_wdata = 32'h0; mret = 1'b1;
    tick();
    csr_op = 2'b00; mret = 1'b0;
    rd_expect("mret_vs_wr", 12'h300, 32'h1888);
    tick();

    // External line latency, then reset during a request
    csr_do(12'h304, 2'b01, 32'h800);
    ext_irq = 1'b1;
`ifdef IRQ_CTRL_EXT_SYNC_EN
    rd_expect("ext_mip_n0", 12'h344, 32'h0);
    tick();
    rd_expect("ext_mip_n1", 12'h344, 32'h0);
    tick();
    rd_expect("ext_mip_n2", 12'h344, 32'h800);
    check("ext_req_n2", 32'(irq_req), 32'h0);
    tick();
`else
    rd_expect("ext_mip_n0", 12'h344, 32'h800);
    tick();
`endif
    check("ext_req", 32'(irq_req), 32'h1);
    check("ext_cause", irq_cause, 32'h8000_000B);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(irq_req), 32'h0);
    check("async_rst_cause", irq_cause, 32'h0);
    check("async_rst_mie", 32'(mie_global), 32'h0);
    model_reset();
    ext_irq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd_expect("post_rst_mie", 12'h304, 32'h0);

    // Randomized traffic
    csr_do(12'h304, 2'b01, 32'h888);
    csr_do(12'h300, 2'b01, 32'h8);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) timer_irq = ~timer_irq;
      if ($urandom_range(0, 7) == 0) sw_irq = ~sw_irq;
      if ($urandom_range(0, 7) == 0) ext_irq = ~ext_irq;
      csr_op = 2'b00; irq_ack = 1'b0; mret = 1'b0;
      case ($urandom_range(0, 3))
        0:       csr_addr = 12'h300;
        1:       csr_addr = 12'h304;
        2:       csr_addr = 12'h344;
        default: csr_addr = 12'($urandom_range(0, 4095));
      endcase
      if ($urandom_range(0, 3) == 0) begin
        csr_op = 2'($urandom_range(1, 3));
        csr_wdata = $urandom;
      end
      if (m_req && $urandom_range(0, 2) == 0) irq_ack = 1'b1;
      if ($urandom_range(0, 9) == 0) mret = 1'b1;
      #1;
      check("rnd_rdata", csr_rdata, m_read(csr_addr));
      check("rnd_hit", 32'(csr_hit), 32'(m_hit(csr_addr)));
      tick();
    end
    csr_op = 2'b00; irq_ack = 1'b0; mret = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
